rob: RTL and testbench

Reorder buffer directly downstream of the reservation station and load/store buffer. Allocates an entry per issued instruction and captures results broadcast on the RS and LSB result buses. Retires entries strictly in program order to the register file and store path. Resolves branch prediction at commit and drives the global `rob_clear_up` flush consumed by RS, LSB and the front end.

---
 rtl/rob_pkg.sv | 27 ++
 rtl/rob_query.sv | 36 +++
 rtl/rob.sv | 162 ++++++++++++++++
 tb/tb_rob.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// Reorder buffer shared definitions.
//   ROB_BIT / ROB_SIZE : index width and entry count
//   rob_type_e         : entry kind encodings (REG, STORE, BRANCH, EXIT)
//   rob_entry_t        : per-entry bookkeeping record
package rob_pkg;

    localparam int ROB_BIT  = 3;
    localparam int ROB_SIZE = 1 << ROB_BIT;

    typedef enum logic [1:0] {
        ROB_TYPE_REG    = 2'd0,
        ROB_TYPE_STORE  = 2'd1,
        ROB_TYPE_BRANCH = 2'd2,
        ROB_TYPE_EXIT   = 2'd3
    } rob_type_e;

    typedef struct packed {
        logic        busy;
        logic        ready;
        rob_type_e   kind;
        logic [4:0]  rd;
        logic [31:0] value;
        logic        pred_taken;
        logic [31:0] alt_pc;
    } rob_entry_t;

endpackage

// File: rtl/rob_query.sv
// Combinational operand lookup into the reorder buffer.
//   entry                    : index being looked up
//   ready_vec / value_vec    : registered per-entry ready flags and values
//   rs_* / lsb_*             : result buses, bypassed in the same cycle
//   ready / value            : lookup result (RS bus wins over LSB bus)
module rob_query
    import rob_pkg::*;
(
    input  logic [ROB_BIT-1:0]               entry,
    input  logic [ROB_SIZE-1:0]              ready_vec,
    input  logic [ROB_SIZE-1:0][31:0]        value_vec,
    input  logic                             rs_ready,
    input  logic [ROB_BIT-1:0]               rs_rob_entry,
    input  logic [31:0]                      rs_value,
    input  logic                             lsb_ready,
    input  logic [ROB_BIT-1:0]               lsb_rob_entry,
    input  logic [31:0]                      lsb_value,
    output logic                             ready,
    output logic [31:0]                      value
);

    always_comb begin
        ready = ready_vec[entry];
        value = value_vec[entry];
        if (lsb_ready && lsb_rob_entry == entry) begin
            ready = 1'b1;
            value = lsb_value;
        end
        // Applied last so an RS hit overrides an LSB hit.
        if (rs_ready && rs_rob_entry == entry) begin
            ready = 1'b1;
            value = rs_value;
        end
    end

endmodule

// File: rtl/rob.sv
// Reorder buffer: allocates an entry per issued instruction, captures results
// from the RS and LSB buses, retires in order and flushes on a branch
// mispredict discovered at commit.
//   clk_in, rst_in (async, active-low), rdy_in (low freezes state)
//   issue_*            : tail allocation; issue_entry/rob_full report tail/full
//   rs_* / lsb_*       : result buses
//   q1_* / q2_*        : operand lookups with same-cycle bus bypass
//   commit_*           : registered register-write retirement
//   store_commit       : head store may write memory
//   rob_clear_up       : flush pulse, redirect_pc valid with it
//   exit_commit        : sticky EXIT-retired flag
module rob
    import rob_pkg::*;
(
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    input  logic               issue_valid,
    input  logic [1:0]         issue_type,
    input  logic [4:0]         issue_rd,
    input  logic               issue_pred_taken,
    input  logic [31:0]        issue_alt_pc,
    output logic [ROB_BIT-1:0] issue_entry,
    output logic               rob_full,
    input  logic               rs_ready,
    input  logic [ROB_BIT-1:0] rs_rob_entry,
    input  logic [31:0]        rs_value,
    input  logic               lsb_ready,
    input  logic [ROB_BIT-1:0] lsb_rob_entry,
    input  logic [31:0]        lsb_value,
    input  logic [ROB_BIT-1:0] q1_entry,
    input  logic [ROB_BIT-1:0] q2_entry,
    output logic               q1_ready,
    output logic               q2_ready,
    output logic [31:0]        q1_value,
    output logic [31:0]        q2_value,
    output logic               commit_valid,
    output logic [4:0]         commit_rd,
    output logic [31:0]        commit_value,
    output logic [ROB_BIT-1:0] commit_entry,
    output logic               store_commit,
    output logic               rob_clear_up,
    output logic [31:0]        redirect_pc,
    output logic               exit_commit
);

    rob_entry_t [ROB_SIZE-1:0] ent;
    logic [ROB_BIT-1:0]        head;
    logic [ROB_BIT-1:0]        tail;
    logic [ROB_BIT:0]          count;

    rob_entry_t h;
    logic       do_commit;
    logic       do_issue;
    logic       mispredict;
    logic       reg_write;

    assign issue_entry = tail;
    assign rob_full    = (count == (ROB_BIT+1)'(ROB_SIZE));

    assign h          = ent[head];
    assign do_commit  = h.busy && h.ready;
    assign do_issue   = issue_valid && !rob_full;
    assign mispredict = do_commit && h.kind == ROB_TYPE_BRANCH && (h.value[0] != h.pred_taken);
    assign reg_write  = do_commit && h.kind == ROB_TYPE_REG && h.rd != 5'd0;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            ent          <= '0;
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            commit_valid <= 1'b0;
            commit_rd    <= '0;
            commit_value <= '0;
            commit_entry <= '0;
            store_commit <= 1'b0;
            rob_clear_up <= 1'b0;
            redirect_pc  <= '0;
            exit_commit  <= 1'b0;
        end else if (!rdy_in) begin
            commit_valid <= 1'b0;
            store_commit <= 1'b0;
            rob_clear_up <= 1'b0;
        end else begin
            commit_valid <= reg_write;
            store_commit <= do_commit && h.kind == ROB_TYPE_STORE;
            rob_clear_up <= mispredict;
            if (do_commit && h.kind == ROB_TYPE_EXIT)
                exit_commit <= 1'b1;
            if (reg_write) begin
                commit_rd    <= h.rd;
                commit_value <= h.value;
                commit_entry <= head;
            end

            if (mispredict) begin
                // Everything younger than the branch is wrong-path; this
                // cycle's issue and writebacks are dropped with it.
                redirect_pc <= h.alt_pc;
                head        <= '0;
                tail        <= '0;
                count       <= '0;
                for (int i = 0; i < ROB_SIZE; i++) begin
                    ent[i].busy  <= 1'b0;
                    ent[i].ready <= 1'b0;
                end
            end else begin
                if (rs_ready && ent[rs_rob_entry].busy) begin
                    ent[rs_rob_entry].ready <= 1'b1;
                    ent[rs_rob_entry].value <= rs_value;
                end
                if (lsb_ready && ent[lsb_rob_entry].busy) begin
                    ent[lsb_rob_entry].ready <= 1'b1;
                    ent[lsb_rob_entry].value <= lsb_value;
                end
                // Tail is never busy when issue is allowed, so the bus
                // writes above cannot collide with this allocation.
                if (do_issue) begin
                    ent[tail] <= '{busy: 1'b1, ready: 1'b0, kind: rob_type_e'(issue_type),
                                   rd: issue_rd, value: 32'd0,
                                   pred_taken: issue_pred_taken, alt_pc: issue_alt_pc};
                    tail <= tail + 1'b1;
                end
                // Ready is cleared too so stale lookups of a retired slot miss.
                if (do_commit) begin
                    ent[head].busy  <= 1'b0;
                    ent[head].ready <= 1'b0;
                    head <= head + 1'b1;
                end
                case ({do_issue, do_commit})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: ;
                endcase
            end
        end
    end

    logic [ROB_SIZE-1:0]       ready_vec;
    logic [ROB_SIZE-1:0][31:0] value_vec;

    for (genvar g = 0; g < ROB_SIZE; g++) begin : g_vec
        assign ready_vec[g] = ent[g].ready;
        assign value_vec[g] = ent[g].value;
    end

    rob_query u_q1 (
        .entry(q1_entry), .ready_vec(ready_vec), .value_vec(value_vec),
        .rs_ready(rs_ready), .rs_rob_entry(rs_rob_entry), .rs_value(rs_value),
        .lsb_ready(lsb_ready), .lsb_rob_entry(lsb_rob_entry), .lsb_value(lsb_value),
        .ready(q1_ready), .value(q1_value)
    );

    rob_query u_q2 (
        .entry(q2_entry), .ready_vec(ready_vec), .value_vec(value_vec),
        .rs_ready(rs_ready), .rs_rob_entry(rs_rob_entry), .rs_value(rs_value),
        .lsb_ready(lsb_ready), .lsb_rob_entry(lsb_rob_entry), .lsb_value(lsb_value),
        .ready(q2_ready), .value(q2_value)
    );

endmodule

// File: tb/tb_rob.sv
// Self-checking bench for rob: directed vector table, hand sequences for
// fill/wrap and async reset, then random traffic against a queue-based model.
module tb_rob;
    import rob_pkg::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, rdy;
    logic        issue_valid, issue_pred_taken;
    logic [1:0]  issue_type;
    logic [4:0]  issue_rd;
    logic [31:0] issue_alt_pc;
    logic [2:0]  issue_entry;
    logic        rob_full;
    logic        rs_ready, lsb_ready;
    logic [2:0]  rs_rob_entry, lsb_rob_entry;
    logic [31:0] rs_value, lsb_value;
    logic [2:0]  q1_entry, q2_entry;
    logic        q1_ready, q2_ready;
    logic [31:0] q1_value, q2_value;
    logic        commit_valid, store_commit, rob_clear_up, exit_commit;
    logic [4:0]  commit_rd;
    logic [31:0] commit_value, redirect_pc;
    logic [2:0]  commit_entry;

    rob dut (
        .clk_in(clk), .rst_in(rst_n), .rdy_in(rdy),
        .issue_valid(issue_valid), .issue_type(issue_type), .issue_rd(issue_rd),
        .issue_pred_taken(issue_pred_taken), .issue_alt_pc(issue_alt_pc),
        .issue_entry(issue_entry), .rob_full(rob_full),
        .rs_ready(rs_ready), .rs_rob_entry(rs_rob_entry), .rs_value(rs_value),
        .lsb_ready(lsb_ready), .lsb_rob_entry(lsb_rob_entry), .lsb_value(lsb_value),
        .q1_entry(q1_entry), .q2_entry(q2_entry),
        .q1_ready(q1_ready), .q2_ready(q2_ready), .q1_value(q1_value), .q2_value(q2_value),
        .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_value(commit_value),
        .commit_entry(commit_entry), .store_commit(store_commit),
        .rob_clear_up(rob_clear_up), .redirect_pc(redirect_pc), .exit_commit(exit_commit)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Two buses naming the same entry in one cycle is illegal stimulus.
    always @(posedge clk)
        if (rst_n && rs_ready && lsb_ready && rs_rob_entry == lsb_rob_entry) begin
            n_fail++;
            $display("FAIL bus_collision: entry %0d on both buses", rs_rob_entry);
        end

    task automatic idle();
        rdy = 1'b1; issue_valid = 1'b0; issue_type = 2'd0; issue_rd = 5'd0;
        issue_pred_taken = 1'b0; issue_alt_pc = 32'd0;
        rs_ready = 1'b0; rs_rob_entry = 3'd0; rs_value = 32'd0;
        lsb_ready = 1'b0; lsb_rob_entry = 3'd0; lsb_value = 32'd0;
        q1_entry = 3'd0; q2_entry = 3'd0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic issue_reg(input logic [4:0] rd);
        @(negedge clk);
        idle();
        issue_valid = 1'b1; issue_type = 2'd0; issue_rd = rd;
        @(posedge clk); #1;
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int          idx;
        logic [1:0]  typ;
        logic [4:0]  rd;
        bit          pred;
        logic [31:0] alt;
        bit          rdy;
        logic [31:0] val;
    } ment_t;

    ment_t       mq[$];
    int          m_tail;
    bit          m_cv, m_sc, m_clr, m_exit;
    logic [4:0]  m_rd;
    logic [31:0] m_val, m_redir;
    int          m_ent;

    task automatic model_reset();
        mq.delete(); m_tail = 0;
        m_cv = 0; m_sc = 0; m_clr = 0; m_exit = 0;
        m_rd = 0; m_val = 0; m_redir = 0; m_ent = 0;
    endtask

    task automatic model_edge();
        ment_t c;
        bit    com, full;
        if (!rdy) begin
            m_cv = 0; m_sc = 0; m_clr = 0;
            return;
        end
        full = (mq.size() == 8);
        com  = (mq.size() > 0) && mq[0].rdy;
        if (com) c = mq[0];
        m_cv  = com && c.typ == 2'd0 && c.rd != 0;
        m_sc  = com && c.typ == 2'd1;
        m_clr = com && c.typ == 2'd2 && (c.val[0] != c.pred);
        if (com && c.typ == 2'd3) m_exit = 1;
        if (m_cv) begin m_rd = c.rd; m_val = c.val; m_ent = c.idx; end
        if (m_clr) begin
            m_redir = c.alt; mq.delete(); m_tail = 0;
            return;
        end
        foreach (mq[k]) begin
            if (rs_ready && mq[k].idx == int'(rs_rob_entry)) begin mq[k].rdy = 1; mq[k].val = rs_value; end
            if (lsb_ready && mq[k].idx == int'(lsb_rob_entry)) begin mq[k].rdy = 1; mq[k].val = lsb_value; end
        end
        if (com) void'(mq.pop_front());
        if (issue_valid && !full) begin
            mq.push_back('{m_tail, issue_type, issue_rd, issue_pred_taken, issue_alt_pc, 0, 32'd0});
            m_tail = (m_tail + 1) % 8;
        end
    endtask

    task automatic exp_q(input logic [2:0] e, output bit r, output logic [31:0] v);
        r = 0; v = 0;
        foreach (mq[k]) if (mq[k].idx == int'(e)) begin r = mq[k].rdy; v = mq[k].val; end
        if (lsb_ready && lsb_rob_entry == e) begin r = 1; v = lsb_value; end
        if (rs_ready && rs_rob_entry == e) begin r = 1; v = rs_value; end
    endtask

    task automatic check_comb();
        bit          r;
        logic [31:0] v;
        chk("issue_entry", issue_entry, m_tail);
        chk("rob_full", rob_full, mq.size() == 8);
        exp_q(q1_entry, r, v);
        chk("q1_ready", q1_ready, r);
        if (r) chk("q1_value", q1_value, v);
        exp_q(q2_entry, r, v);
        chk("q2_ready", q2_ready, r);
        if (r) chk("q2_value", q2_value, v);
    endtask

    task automatic check_reg();
        chk("commit_valid", commit_valid, m_cv);
        chk("store_commit", store_commit, m_sc);
        chk("rob_clear_up", rob_clear_up, m_clr);
        chk("exit_commit", exit_commit, m_exit);
        chk("commit_rd", commit_rd, m_rd);
        chk("commit_value", commit_value, m_val);
        chk("commit_entry", commit_entry, m_ent);
        chk("redirect_pc", redirect_pc, m_redir);
    endtask

    function automatic logic [2:0] pick_entry();
        if (mq.size() > 0 && ($urandom % 4) != 0)
            return 3'(mq[$urandom % mq.size()].idx);
        return 3'($urandom % 8);
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        bit iv; logic [1:0] it; logic [4:0] rd; bit pred; logic [31:0] alt;
        bit rsr; logic [2:0] rse; logic [31:0] rsv;
        bit lr;  logic [2:0] le;  logic [31:0] lv;
        logic [2:0] q1; bit eq1r; logic [31:0] eq1v;
        bit ecv; logic [4:0] erd; logic [31:0] eval; logic [2:0] eent;
        bit eclr; logic [31:0] eredir; logic [2:0] eie;
    } vec_t;

    vec_t vt[18];

    initial begin
        vt[0]  = '{1,0,5,0,0,        0,0,0,          0,0,0,        0, 0,0,           0,0,0,0,              0,0,       1};
        vt[1]  = '{0,0,0,0,0,        1,0,32'h1234,   0,0,0,        0, 1,32'h1234,    0,0,0,0,              0,0,       1};
        vt[2]  = '{0,0,0,0,0,        0,0,0,          0,0,0,        0, 1,32'h1234,    1,5,32'h1234,0,       0,0,       1};
        vt[3]  = '{0,0,0,0,0,        0,0,0,          0,0,0,        2, 0,0,           0,0,0,0,              0,0,       1};
        vt[4]  = '{1,0,7,0,0,        0,0,0,          0,0,0,        2, 0,0,           0,0,0,0,              0,0,       2};
        vt[5]  = '{1,0,9,0,0,        0,0,0,          0,0,0,        2, 0,0,           0,0,0,0,              0,0,       3};
        vt[6]  = '{0,0,0,0,0,        1,2,32'hBEEF,   0,0,0,        2, 1,32'hBEEF,    0,0,0,0,              0,0,       3};
        vt[7]  = '{0,0,0,0,0,        0,0,0,          0,0,0,        2, 1,32'hBEEF,    0,0,0,0,              0,0,       3};
        vt[8]  = '{0,0,0,0,0,        0,0,0,          1,1,32'h55,   1, 1,32'h55,      0,0,0,0,              0,0,       3};
        vt[9]  = '{0,0,0,0,0,        0,0,0,          0,0,0,        1, 1,32'h55,      1,7,32'h55,1,         0,0,       3};
        vt[10] = '{0,0,0,0,0,        0,0,0,          0,0,0,        2, 1,32'hBEEF,    1,9,32'hBEEF,2,       0,0,       3};
        vt[11] = '{0,0,0,0,0,        1,2,7,          0,0,0,        2, 1,7,           0,0,0,0,              0,0,       3};
        vt[12] = '{0,0,0,0,0,        0,0,0,          0,0,0,        2, 0,0,           0,0,0,0,              0,0,       3};
        vt[13] = '{1,2,0,0,32'h100,  0,0,0,          0,0,0,        3, 0,0,           0,0,0,0,              0,0,       4};
        vt[14] = '{1,0,3,0,0,        0,0,0,          0,0,0,        3, 0,0,           0,0,0,0,              0,0,       5};
        vt[15] = '{0,0,0,0,0,        1,3,1,          0,0,0,        3, 1,1,           0,0,0,0,              0,0,       5};
        vt[16] = '{1,0,4,0,0,        0,0,0,          0,0,0,        3, 1,1,           0,0,0,0,              1,32'h100, 0};
        vt[17] = '{0,0,0,0,0,        0,0,0,          0,0,0,        4, 0,0,           0,0,0,0,              0,0,       0};

        idle();
        do_reset();

        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            idle();
            issue_valid = vt[i].iv; issue_type = vt[i].it; issue_rd = vt[i].rd;
            issue_pred_taken = vt[i].pred; issue_alt_pc = vt[i].alt;
            rs_ready = vt[i].rsr; rs_rob_entry = vt[i].rse; rs_value = vt[i].rsv;
            lsb_ready = vt[i].lr; lsb_rob_entry = vt[i].le; lsb_value = vt[i].lv;
            q1_entry = vt[i].q1;
            #1;
            chk($sformatf("vec%0d q1_ready", i), q1_ready, vt[i].eq1r);
            if (vt[i].eq1r) chk($sformatf("vec%0d q1_value", i), q1_value, vt[i].eq1v);
            @(posedge clk); #1;
            chk($sformatf("vec%0d commit_valid", i), commit_valid, vt[i].ecv);
            if (vt[i].ecv) begin
                chk($sformatf("vec%0d commit_rd", i), commit_rd, vt[i].erd);
                chk($sformatf("vec%0d commit_value", i), commit_value, vt[i].eval);
                chk($sformatf("vec%0d commit_entry", i), commit_entry, vt[i].eent);
            end
            chk($sformatf("vec%0d rob_clear_up", i), rob_clear_up, vt[i].eclr);
            if (vt[i].eclr) chk($sformatf("vec%0d redirect_pc", i), redirect_pc, vt[i].eredir);
            chk($sformatf("vec%0d issue_entry", i), issue_entry, vt[i].eie);
        end

        // ---- async reset with 3 entries in flight ----
        issue_reg(5'd1); issue_reg(5'd2); issue_reg(5'd3);
        @(negedge clk); idle();
        #2 rst_n = 1'b0;
        #1;
        chk("rst issue_entry", issue_entry, 0);
        chk("rst rob_full", rob_full, 0);
        chk("rst commit_valid", commit_valid, 0);
        chk("rst commit_rd", commit_rd, 0);
        chk("rst commit_value", commit_value, 0);
        chk("rst redirect_pc", redirect_pc, 0);
        chk("rst rob_clear_up", rob_clear_up, 0);
        chk("rst store_commit", store_commit, 0);
        chk("rst exit_commit", exit_commit, 0);
        chk("rst q1_ready", q1_ready, 0);
        chk("rst q1_value", q1_value, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post-rst issue_entry", issue_entry, 0);

        // ---- fill, overflow, wrap ----
        for (int i = 0; i < 8; i++) issue_reg(5'(i + 1));
        chk("fill rob_full", rob_full, 1);
        chk("fill issue_entry", issue_entry, 0);
        issue_reg(5'd31);
        chk("overflow rob_full", rob_full, 1);
        chk("overflow issue_entry", issue_entry, 0);
        @(negedge clk); idle();
        rs_ready = 1; rs_rob_entry = 3'd0; rs_value = 32'hAAAA0000;
        lsb_ready = 1; lsb_rob_entry = 3'd1; lsb_value = 32'h0000BBBB;
        @(posedge clk); #1;
        @(negedge clk); idle();
        @(posedge clk); #1;
        chk("wrap commit0 valid", commit_valid, 1);
        chk("wrap commit0 value", commit_value, 32'hAAAA0000);
        chk("wrap commit0 entry", commit_entry, 0);
        chk("wrap commit0 full", rob_full, 0);
        issue_reg(5'd20);
        chk("wrap commit1 valid", commit_valid, 1);
        chk("wrap commit1 value", commit_value, 32'h0000BBBB);
        chk("wrap commit1 entry", commit_entry, 1);
        chk("wrap issue+commit full", rob_full, 0);
        chk("wrap issue_entry", issue_entry, 1);
        issue_reg(5'd21);
        chk("refill rob_full", rob_full, 1);
        chk("refill issue_entry", issue_entry, 2);

        // ---- random traffic vs model ----
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int r;
            @(negedge clk);
            rdy = ($urandom % 10) != 0;
            issue_valid = $urandom % 2;
            r = $urandom % 20;
            issue_type = (r < 12) ? 2'd0 : (r < 15) ? 2'd1 : (r < 19) ? 2'd2 : 2'd3;
            issue_rd = 5'($urandom % 32);
            issue_pred_taken = $urandom % 2;
            issue_alt_pc = $urandom;
            rs_ready = $urandom % 2; rs_rob_entry = pick_entry(); rs_value = $urandom;
            lsb_ready = $urandom % 2; lsb_rob_entry = pick_entry(); lsb_value = $urandom;
            if (rs_ready && lsb_ready && rs_rob_entry == lsb_rob_entry) lsb_ready = 0;
            q1_entry = 3'($urandom % 8); q2_entry = 3'($urandom % 8);
            #1;
            check_comb();
            @(posedge clk);
            model_edge();
            #1;
            check_reg();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
